audio_channel_aligner: RTL and testbench



---
 rtl/audio_channel_aligner.sv | 119 +++++++++++
 tb/tb_audio_channel_aligner.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_channel_aligner.sv
// ---------------------------------------------------------------------------
// audio_channel_aligner
//
// Stereo channel-order repair stage. It sits between the echo effect output
// and the S/PDIF encoder input. The output always follows a strict
// left, right, left, ... order. When upstream drops a channel, this block
// inserts a zero sample for the missing channel and counts the insertion.
//
// The output stage is registered (valid/ready). A one-entry pending register
// holds the mismatching input sample while the inserted zero drains. Because
// i_ready depends only on registers and o_ready, there is no combinational
// path from i_valid to i_ready.
//
// Ports:
//   clk             system clock, rising edge
//   nreset          asynchronous active-low reset
//   i_valid         upstream sample valid
//   i_ready         block accepts the input sample
//   i_is_left       channel of the input sample (1 = left)
//   i_audio         input sample, two's complement
//   o_valid         output sample valid
//   o_ready         downstream accepts the output sample
//   o_is_left       channel of the output sample
//   o_audio         output sample
//   o_insert_count  number of inserted zero samples, saturating
// ---------------------------------------------------------------------------
module audio_channel_aligner #(
    parameter int audio_width = 16,
    parameter int count_width = 8
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_is_left,
    input  logic [audio_width-1:0] i_audio,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   o_is_left,
    output logic [audio_width-1:0] o_audio,
    output logic [count_width-1:0] o_insert_count
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [count_width-1:0] COUNT_MAX = {count_width{1'b1}};
    localparam logic [count_width-1:0] COUNT_ONE = {{(count_width-1){1'b0}}, 1'b1};

    logic [0:0]             state;
    logic                   expect_left;
    logic                   pend_is_left;
    logic [audio_width-1:0] pend_audio;

    logic out_free;
    logic in_fire;

    // The output register can take a new sample when it is empty or is
    // being consumed this cycle. This allows a consume and a load in the
    // same cycle, so the stream runs at full rate.
    assign out_free = !o_valid || o_ready;
    assign i_ready  = out_free && (state == RUN);
    assign in_fire  = i_valid && i_ready;

    // Main sequencer. In RUN, a matching input goes straight to the output
    // register. A mismatching input makes the block emit a zero for the
    // expected channel first and park the input in the pending register.
    // The parked sample always belongs to the channel that comes next, so
    // one PEND cycle always resolves the mismatch.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= RUN;
            expect_left    <= 1'b1;
            pend_is_left   <= 1'b0;
            pend_audio     <= '0;
            o_valid        <= 1'b0;
            o_is_left      <= 1'b0;
            o_audio        <= '0;
            o_insert_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (in_fire) begin
                        o_valid     <= 1'b1;
                        expect_left <= !expect_left;
                        if (i_is_left == expect_left) begin
                            o_is_left <= i_is_left;
                            o_audio   <= i_audio;
                        end else begin
                            o_is_left    <= expect_left;
                            o_audio      <= '0;
                            pend_is_left <= i_is_left;
                            pend_audio   <= i_audio;
                            state        <= PEND;
                            if (o_insert_count != COUNT_MAX) begin
                                o_insert_count <= o_insert_count + COUNT_ONE;
                            end
                        end
                    end else if (o_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                PEND: begin
                    if (out_free) begin
                        o_valid     <= 1'b1;
                        o_is_left   <= pend_is_left;
                        o_audio     <= pend_audio;
                        expect_left <= !expect_left;
                        state       <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_channel_aligner.sv
// ---------------------------------------------------------------------------
// tb_audio_channel_aligner
//
// Directed testbench for audio_channel_aligner. Each scenario task drives
// stimulus one cycle at a time and compares the outputs against
// hand-computed expected values.
//
// Timing: inputs change 1 time unit after the rising edge. Outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_audio_channel_aligner;

    logic        clk;
    logic        nreset;
    logic        i_valid;
    logic        i_ready;
    logic        i_is_left;
    logic [15:0] i_audio;
    logic        o_valid;
    logic        o_ready;
    logic        o_is_left;
    logic [15:0] o_audio;
    logic [7:0]  o_insert_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    audio_channel_aligner #(
        .audio_width(16),
        .count_width(8)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_is_left     (i_is_left),
        .i_audio       (i_audio),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_is_left     (o_is_left),
        .o_audio       (o_audio),
        .o_insert_count(o_insert_count)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset for two edges, then releases it on a falling edge with
    // the inputs idle.
    task automatic do_reset();
        nreset    = 1'b0;
        i_valid   = 1'b0;
        i_is_left = 1'b0;
        i_audio   = 16'h0000;
        o_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Drives one cycle of inputs just after the rising edge, then waits
    // for the falling edge so the caller can sample outputs.
    task automatic apply_stimulus(input logic ordy, input logic iv,
                                  input logic il, input logic [15:0] id);
        @(posedge clk);
        #1;
        o_ready   = ordy;
        i_valid   = iv;
        i_is_left = il;
        i_audio   = id;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nreset    = 1'b0;
        i_valid   = 1'b0;
        i_is_left = 1'b0;
        i_audio   = 16'h0000;
        o_ready   = 1'b1;
        #2;
        n_compared++;
        if ({o_valid, o_is_left, o_audio} !== 18'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got %b/%b/%h expected 0/0/0000", o_valid, o_is_left, o_audio);
        end
        n_compared++;
        if (o_insert_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count: got %0d expected 0", o_insert_count);
        end
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        n_compared++;
        if (i_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_i_ready: got %b expected 1", i_ready);
        end
    endtask

    // Per cycle: stim = {o_ready, i_valid, i_is_left, i_audio},
    // expv = {i_ready, o_valid, o_is_left, o_audio}.
    task automatic test_clean();
        logic [18:0] stim [6] = '{
            {1'b1, 1'b1, 1'b1, 16'h1234}, {1'b1, 1'b1, 1'b0, 16'h5678},
            {1'b1, 1'b1, 1'b1, 16'h0001}, {1'b1, 1'b1, 1'b0, 16'hFFFF},
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        logic [18:0] expv [6] = '{
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b1, 1'b1, 1'b1, 16'h1234},
            {1'b1, 1'b1, 1'b0, 16'h5678}, {1'b1, 1'b1, 1'b1, 16'h0001},
            {1'b1, 1'b1, 1'b0, 16'hFFFF}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(stim[i][18], stim[i][17], stim[i][16], stim[i][15:0]);
            n_compared++;
            if (i_ready !== expv[i][18]) begin
                n_mismatched++;
                $display("[TB] FAIL clean_i_ready[%0d]: got %b expected %b", i, i_ready, expv[i][18]);
            end
            n_compared++;
            if (o_valid !== expv[i][17]) begin
                n_mismatched++;
                $display("[TB] FAIL clean_o_valid[%0d]: got %b expected %b", i, o_valid, expv[i][17]);
            end
            if (expv[i][17]) begin
                n_compared++;
                if ({o_is_left, o_audio} !== expv[i][16:0]) begin
                    n_mismatched++;
                    $display("[TB] FAIL clean_data[%0d]: got %b/%h expected %b/%h", i, o_is_left, o_audio, expv[i][16], expv[i][15:0]);
                end
            end
        end
        n_compared++;
        if (o_insert_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL clean_count: got %0d expected 0", o_insert_count);
        end
    endtask

    // L,L,R input: the second L forces a zero R insertion. R 0x3333 stays
    // offered during the PEND cycle and is taken afterwards.
    task automatic test_duplicate_left();
        logic [18:0] stim [6] = '{
            {1'b1, 1'b1, 1'b1, 16'h1111}, {1'b1, 1'b1, 1'b1, 16'h2222},
            {1'b1, 1'b1, 1'b0, 16'h3333}, {1'b1, 1'b1, 1'b0, 16'h3333},
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        logic [18:0] expv [6] = '{
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b1, 1'b1, 1'b1, 16'h1111},
            {1'b0, 1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 1'b1, 16'h2222},
            {1'b1, 1'b1, 1'b0, 16'h3333}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(stim[i][18], stim[i][17], stim[i][16], stim[i][15:0]);
            n_compared++;
            if (i_ready !== expv[i][18]) begin
                n_mismatched++;
                $display("[TB] FAIL dup_i_ready[%0d]: got %b expected %b", i, i_ready, expv[i][18]);
            end
            n_compared++;
            if (o_valid !== expv[i][17]) begin
                n_mismatched++;
                $display("[TB] FAIL dup_o_valid[%0d]: got %b expected %b", i, o_valid, expv[i][17]);
            end
            if (expv[i][17]) begin
                n_compared++;
                if ({o_is_left, o_audio} !== expv[i][16:0]) begin
                    n_mismatched++;
                    $display("[TB] FAIL dup_data[%0d]: got %b/%h expected %b/%h", i, o_is_left, o_audio, expv[i][16], expv[i][15:0]);
                end
            end
        end
        n_compared++;
        if (o_insert_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL dup_count: got %0d expected 1", o_insert_count);
        end
    endtask

    // A right sample first after reset: a zero left comes out first, then
    // the right sample.
    task automatic test_right_first();
        logic [18:0] stim [4] = '{
            {1'b1, 1'b1, 1'b0, 16'h7FFF}, {1'b1, 1'b0, 1'b0, 16'h0000},
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        logic [18:0] expv [4] = '{
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b0, 1'b1, 1'b1, 16'h0000},
            {1'b1, 1'b1, 1'b0, 16'h7FFF}, {1'b1, 1'b0, 1'b0, 16'h0000}};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(stim[i][18], stim[i][17], stim[i][16], stim[i][15:0]);
            n_compared++;
            if (i_ready !== expv[i][18]) begin
                n_mismatched++;
                $display("[TB] FAIL rfirst_i_ready[%0d]: got %b expected %b", i, i_ready, expv[i][18]);
            end
            n_compared++;
            if (o_valid !== expv[i][17]) begin
                n_mismatched++;
                $display("[TB] FAIL rfirst_o_valid[%0d]: got %b expected %b", i, o_valid, expv[i][17]);
            end
            if (expv[i][17]) begin
                n_compared++;
                if ({o_is_left, o_audio} !== expv[i][16:0]) begin
                    n_mismatched++;
                    $display("[TB] FAIL rfirst_data[%0d]: got %b/%h expected %b/%h", i, o_is_left, o_audio, expv[i][16], expv[i][15:0]);
                end
            end
        end
        n_compared++;
        if (o_insert_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL rfirst_count: got %0d expected 1", o_insert_count);
        end
    endtask

    // L 0xAAAA is held for 5 cycles with o_ready low while R 0xBBBB waits.
    // When o_ready rises, 0xAAAA is consumed in the same cycle that
    // 0xBBBB is accepted.
    task automatic test_backpressure();
        logic [18:0] stim [9] = '{
            {1'b0, 1'b1, 1'b1, 16'hAAAA}, {1'b0, 1'b1, 1'b0, 16'hBBBB},
            {1'b0, 1'b1, 1'b0, 16'hBBBB}, {1'b0, 1'b1, 1'b0, 16'hBBBB},
            {1'b0, 1'b1, 1'b0, 16'hBBBB}, {1'b0, 1'b1, 1'b0, 16'hBBBB},
            {1'b1, 1'b1, 1'b0, 16'hBBBB}, {1'b1, 1'b0, 1'b0, 16'h0000},
            {1'b1, 1'b0, 1'b0, 16'h0000}};
        logic [18:0] expv [9] = '{
            {1'b1, 1'b0, 1'b0, 16'h0000}, {1'b0, 1'b1, 1'b1, 16'hAAAA},
            {1'b0, 1'b1, 1'b1, 16'hAAAA}, {1'b0, 1'b1, 1'b1, 16'hAAAA},
            {1'b0, 1'b1, 1'b1, 16'hAAAA}, {1'b0, 1'b1, 1'b1, 16'hAAAA},
            {1'b1, 1'b1, 1'b1, 16'hAAAA}, {1'b1, 1'b1, 1'b0, 16'hBBBB},
            {1'b1, 1'b0, 1'b0, 16'h0000}};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(stim[i][18], stim[i][17], stim[i][16], stim[i][15:0]);
            n_compared++;
            if (i_ready !== expv[i][18]) begin
                n_mismatched++;
                $display("[TB] FAIL bp_i_ready[%0d]: got %b expected %b", i, i_ready, expv[i][18]);
            end
            n_compared++;
            if (o_valid !== expv[i][17]) begin
                n_mismatched++;
                $display("[TB] FAIL bp_o_valid[%0d]: got %b expected %b", i, o_valid, expv[i][17]);
            end
            if (expv[i][17]) begin
                n_compared++;
                if ({o_is_left, o_audio} !== expv[i][16:0]) begin
                    n_mismatched++;
                    $display("[TB] FAIL bp_data[%0d]: got %b/%h expected %b/%h", i, o_is_left, o_audio, expv[i][16], expv[i][15:0]);
                end
            end
        end
        n_compared++;
        if (o_insert_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_count: got %0d expected 0", o_insert_count);
        end
    endtask

    // 300 left-only samples with values 1..300. Every sample after the
    // first forces a zero right insertion, so 299 insertions saturate the
    // counter at 255. The output must alternate L(k), R(0), L(k+1), ...
    task automatic test_saturation();
        int   sent     = 0;
        int   got_l    = 0;
        int   got_r    = 0;
        logic exp_left = 1'b1;
        bit   done     = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(posedge clk);
            #1;
            o_ready   = 1'b1;
            i_valid   = (sent < 300);
            i_is_left = 1'b1;
            i_audio   = 16'(sent + 1);
            @(negedge clk);
            if (o_valid) begin
                n_compared++;
                if ({o_is_left, o_audio} !== {exp_left, (exp_left ? 16'(got_l + 1) : 16'h0000)}) begin
                    n_mismatched++;
                    $display("[TB] FAIL sat_order[L%0d/R%0d]: got %b/%h expected %b/%h", got_l, got_r, o_is_left, o_audio, exp_left, (exp_left ? 16'(got_l + 1) : 16'h0000));
                end
                if (exp_left) got_l++;
                else          got_r++;
                exp_left = !exp_left;
            end
            if (i_valid && i_ready) sent++;
            if (sent == 300 && !o_valid) done = 1'b1;
        end
        n_compared++;
        if (!done) begin
            n_mismatched++;
            $display("[TB] FAIL sat_timeout: got %0d sent expected 300 sent and drained", sent);
        end
        n_compared++;
        if (got_l != 300 || got_r != 299) begin
            n_mismatched++;
            $display("[TB] FAIL sat_totals: got L=%0d R=%0d expected L=300 R=299", got_l, got_r);
        end
        n_compared++;
        if (o_insert_count !== 8'd255) begin
            n_mismatched++;
            $display("[TB] FAIL sat_count: got %0d expected 255", o_insert_count);
        end
    endtask

    // A mismatch parks R 0x0099 and enters PEND. A reset pulse then drops
    // both the inserted zero and the parked sample.
    task automatic test_reset_in_pend();
        do_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0099);
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        n_compared++;
        if ({i_ready, o_valid, o_is_left, o_audio} !== {1'b0, 1'b1, 1'b1, 16'h0000}) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_setup: got %b/%b/%b/%h expected 0/1/1/0000", i_ready, o_valid, o_is_left, o_audio);
        end
        #1;
        nreset = 1'b0;
        #1;
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_o_valid: got %b expected 0", o_valid);
        end
        n_compared++;
        if (o_insert_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_count: got %0d expected 0", o_insert_count);
        end
        @(negedge clk);
        nreset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 16'h0042);
        n_compared++;
        if (i_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_i_ready: got %b expected 1", i_ready);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        n_compared++;
        if ({o_valid, o_is_left, o_audio} !== {1'b1, 1'b1, 16'h0042}) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_next: got %b/%b/%h expected 1/1/0042", o_valid, o_is_left, o_audio);
        end
        n_compared++;
        if (o_insert_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rpend_count_after: got %0d expected 0", o_insert_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_duplicate_left();
        test_right_first();
        test_backpressure();
        test_saturation();
        test_reset_in_pend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Safety net in case a scenario stalls unexpectedly.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
